alu_result_checker: RTL

ALU_RESULT_CHECKER -- requirements
Module: alu_result_checker

---
 rtl/alu_result_checker_if.sv | 20 ++
 rtl/alu_result_checker.sv | 111 +++++++++++
 2 files changed

// File: rtl/alu_result_checker_if.sv
// Stimulus and result bundle shared by the ALU driver and the result checker.
// The checker observes every signal; the driver owns them all.
interface alu_result_checker_if;
  logic       chk_valid;
  logic [3:0] a;
  logic [3:0] b;
  logic [1:0] sel;
  logic [3:0] dut_out;
  logic       dut_ovf;

  modport master (
    output chk_valid, a, b, sel,
    output dut_out, dut_ovf
  );

  modport slave (
    input chk_valid, a, b, sel,
    input dut_out, dut_ovf
  );
endinterface

// File: rtl/alu_result_checker.sv
// Scoreboard for a 4-bit ALU: predicts each result, delays it by LATENCY
// cycles and compares it against the observed ALU output.
module alu_result_checker #(
  parameter int LATENCY = 1,
  parameter int CNT_W   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  alu_result_checker_if.slave   alu,
  input  logic                  clear,
  output logic                  mismatch,
  output logic                  fail,
  output logic [CNT_W-1:0]      check_cnt,
  output logic [CNT_W-1:0]      err_cnt,
  output logic [14:0]           fail_info
);

  localparam int PW = LATENCY * 15;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PASS,
    S_FAIL
  } state_t;

  state_t state;

  logic [4:0]  sum;
  logic [4:0]  dif;
  logic [3:0]  exp_out;
  logic        exp_ovf;
  logic [14:0] stim;

  logic [LATENCY-1:0]       vld;
  logic [LATENCY-1:0][14:0] rec;

  logic cmp_vld;
  logic cmp_bad;

  // Bit 4 of the 5-bit difference is the unsigned borrow.
  always_comb begin
    sum     = {1'b0, alu.a} + {1'b0, alu.b};
    dif     = {1'b0, alu.a} - {1'b0, alu.b};
    exp_out = '0;
    exp_ovf = 1'b0;
    unique case (alu.sel)
      2'b00: {exp_ovf, exp_out} = sum;
      2'b01: {exp_ovf, exp_out} = dif;
      2'b10: exp_out = alu.a & alu.b;
      2'b11: exp_out = alu.a | alu.b;
      default: exp_out = '0;
    endcase
  end

  assign stim = {alu.a, alu.b, alu.sel,
                 exp_out, exp_ovf};

  assign cmp_vld = vld[LATENCY-1];
  assign cmp_bad = {alu.dut_out, alu.dut_ovf}
                   != rec[LATENCY-1][4:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld <= '0;
      rec <= '0;
    end else begin
      if (clear)
        vld <= '0;
      else
        vld <= LATENCY'({vld, alu.chk_valid});
      rec <= PW'({rec, stim});
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      mismatch  <= 1'b0;
      fail      <= 1'b0;
      check_cnt <= '0;
      err_cnt   <= '0;
      fail_info <= '0;
    end else if (clear) begin
      state     <= S_IDLE;
      mismatch  <= 1'b0;
      fail      <= 1'b0;
      check_cnt <= '0;
      err_cnt   <= '0;
      fail_info <= '0;
    end else begin
      mismatch <= 1'b0;
      if (cmp_vld) begin
        if (check_cnt != '1)
          check_cnt <= check_cnt + CNT_W'(1);
        if (cmp_bad) begin
          mismatch <= 1'b1;
          if (err_cnt != '1)
            err_cnt <= err_cnt + CNT_W'(1);
          if (state != S_FAIL) begin
            state     <= S_FAIL;
            fail      <= 1'b1;
            fail_info <= rec[LATENCY-1];
          end
        end else if (state == S_IDLE) begin
          state <= S_PASS;
        end
      end
    end
  end

endmodule
